// File: rtl/clock_divider_bank.sv
`default_nettype none
// ============================================================================
//  Module      : clock_divider_bank
//  Description : Multi-channel 50%-duty clock divider with glitch-free divisor
//                updates, glitch-free enable/disable and common phase sync.
//  Revision    : 1.0 - initial release
// ============================================================================
module clock_divider_bank #(
  parameter int CHANNELS = 3,
  parameter int WIDTH    = 16
) (
  input  logic                      clock_in,
  input  logic                      reset_n,
  input  logic [CHANNELS-1:0]       enable,
  input  logic [CHANNELS-1:0]       load,
  input  logic [CHANNELS*WIDTH-1:0] half_period,
  input  logic                      sync,
  output logic [CHANNELS-1:0]       clock_out,
  output logic [CHANNELS-1:0]       tick,
  output logic [CHANNELS-1:0]       busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] C_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
    state_t           r_state;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_lim;
    logic [WIDTH-1:0] r_pend;
    logic             r_pend_valid;
    logic             r_clk;
    logic             r_tick;
    logic             r_busy;

    logic [WIDTH-1:0] w_hp;
    logic [WIDTH-1:0] w_next_lim;
    logic             w_at_lim;

    assign w_hp = half_period[k*WIDTH +: WIDTH];
    // A load arriving in the same cycle as a boundary wins over the pending value.
    assign w_next_lim = load[k] ? w_hp : (r_pend_valid ? r_pend : r_lim);
    assign w_at_lim   = (r_cnt >= r_lim);

    always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
        r_state      <= ST_IDLE;
        r_cnt        <= '0;
        r_lim        <= '0;
        r_pend       <= '0;
        r_pend_valid <= 1'b0;
        r_clk        <= 1'b0;
        r_tick       <= 1'b0;
        r_busy       <= 1'b0;
      end else begin
        r_tick <= 1'b0;
        if (load[k]) begin
          r_pend       <= w_hp;
          r_pend_valid <= 1'b1;
        end

        if (sync && enable[k]) begin
          r_state      <= ST_LOW;
          r_cnt        <= '0;
          r_clk        <= 1'b0;
          r_busy       <= 1'b1;
          r_lim        <= w_next_lim;
          r_pend_valid <= 1'b0;
        end else begin
          case (r_state)
            ST_IDLE: begin
              r_cnt        <= '0;
              r_clk        <= 1'b0;
              r_lim        <= w_next_lim;
              r_pend_valid <= 1'b0;
              if (enable[k]) begin
                r_state <= ST_LOW;
                r_busy  <= 1'b1;
              end else begin
                r_busy  <= 1'b0;
              end
            end
            ST_LOW: begin
              if (!enable[k]) begin
                r_state <= ST_IDLE;
                r_cnt   <= '0;
                r_busy  <= 1'b0;
              end else if (w_at_lim) begin
                r_state <= ST_HIGH;
                r_cnt   <= '0;
                r_clk   <= 1'b1;
                r_tick  <= 1'b1;
              end else begin
                r_cnt <= r_cnt + C_ONE;
              end
            end
            ST_HIGH: begin
              // The high phase always runs to full length, even once disabled.
              if (w_at_lim) begin
                r_cnt        <= '0;
                r_clk        <= 1'b0;
                r_lim        <= w_next_lim;
                r_pend_valid <= 1'b0;
                if (enable[k]) begin
                  r_state <= ST_LOW;
                end else begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
                end
              end else begin
                r_cnt <= r_cnt + C_ONE;
              end
            end
            default: begin
              r_state <= ST_IDLE;
              r_cnt   <= '0;
              r_clk   <= 1'b0;
              r_busy  <= 1'b0;
            end
          endcase
        end
      end
    end

    assign clock_out[k] = r_clk;
    assign tick[k]      = r_tick;
    assign busy[k]      = r_busy;
  end

endmodule
`default_nettype wire

// File: tb/tb_clock_divider_bank.sv
`default_nettype none
// ============================================================================
//  Module      : tb_clock_divider_bank
//  Description : Directed self-checking bench for clock_divider_bank.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_clock_divider_bank;

  logic        clock_in = 1'b0;
  logic        reset_n  = 1'b1;
  logic [2:0]  enable   = '0;
  logic [2:0]  load     = '0;
  logic [47:0] half_period = '0;
  logic        sync     = 1'b0;
  logic [2:0]  clock_out;
  logic [2:0]  tick;
  logic [2:0]  busy;

  int n_cmp  = 0;
  int n_fail = 0;

  int         rise_t [3][8];
  int         fall_t [3][8];
  int         nr [3];
  int         nf [3];
  int         nhi [3];
  int         tick_bad;
  logic [2:0] prev;
  logic [2:0] snap_a, snap_b;

  clock_divider_bank #(.CHANNELS(3), .WIDTH(16)) dut (
    .clock_in    (clock_in),
    .reset_n     (reset_n),
    .enable      (enable),
    .load        (load),
    .half_period (half_period),
    .sync        (sync),
    .clock_out   (clock_out),
    .tick        (tick),
    .busy        (busy)
  );

  always #5 clock_in = ~clock_in;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock_in);
    #1;
  endtask

  task automatic do_reset();
    enable  = '0;
    load    = '0;
    sync    = 1'b0;
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic clear_watch();
    for (int k = 0; k < 3; k++) begin
      nr[k] = 0;
      nf[k] = 0;
      nhi[k] = 0;
      for (int j = 0; j < 8; j++) begin
        rise_t[k][j] = -1;
        fall_t[k][j] = -1;
      end
    end
    tick_bad = 0;
    prev = clock_out;
  endtask

  // Records rise/fall cycle indices and high-cycle counts; tick must mark each rise.
  task automatic watch(input int c);
    for (int k = 0; k < 3; k++) begin
      if (clock_out[k] && !prev[k]) begin
        if (nr[k] < 8) rise_t[k][nr[k]] = c;
        nr[k]++;
      end
      if (!clock_out[k] && prev[k]) begin
        if (nf[k] < 8) fall_t[k][nf[k]] = c;
        nf[k]++;
      end
      if (clock_out[k]) nhi[k]++;
      if (tick[k] !== (clock_out[k] && !prev[k])) tick_bad++;
    end
    prev = clock_out;
  endtask

  initial begin
    // Reset state, checked asynchronously before any clock edge.
    #1 reset_n = 1'b0;
    #1;
    check("reset_clock_out", clock_out, 0);
    check("reset_tick",      tick,      0);
    check("reset_busy",      busy,      0);
    do_reset();
    check("idle_clock_out", clock_out, 0);
    check("idle_busy",      busy,      0);

    // Test 1: H = 0, 1, 4 loaded in IDLE, then all enabled together.
    load = 3'b111;
    half_period = {16'd4, 16'd1, 16'd0};
    step();
    load = '0;
    enable = 3'b111;
    clear_watch();
    for (int c = 1; c <= 40; c++) begin
      step();
      watch(c);
    end
    check("t1_ch0_first_rise",  rise_t[0][0], 2);
    check("t1_ch0_second_rise", rise_t[0][1], 4);
    check("t1_ch1_first_rise",  rise_t[1][0], 3);
    check("t1_ch1_second_rise", rise_t[1][1], 7);
    check("t1_ch2_first_rise",  rise_t[2][0], 6);
    check("t1_ch2_second_rise", rise_t[2][1], 16);
    check("t1_ch0_rises", nr[0], 20);
    check("t1_ch1_rises", nr[1], 10);
    check("t1_ch2_rises", nr[2], 4);
    check("t1_ch0_high_cycles", nhi[0], 20);
    check("t1_ch1_high_cycles", nhi[1], 20);
    check("t1_ch2_high_cycles", nhi[2], 20);
    check("t1_ch2_first_fall", fall_t[2][0], 11);
    check("t1_tick_align", tick_bad, 0);
    check("t1_busy", busy, 3'b111);

    // Test 2: ch0 H=4, load H=1 during the first high phase.
    do_reset();
    load = 3'b001;
    half_period = {16'd0, 16'd0, 16'd4};
    step();
    load = '0;
    enable = 3'b001;
    clear_watch();
    for (int c = 1; c <= 24; c++) begin
      step();
      watch(c);
      if (c == 7) begin
        load = 3'b001;
        half_period = {16'd0, 16'd0, 16'd1};
      end
      if (c == 8) load = '0;
    end
    check("t2_rise0", rise_t[0][0], 6);
    check("t2_fall0", fall_t[0][0], 11);
    check("t2_rise1", rise_t[0][1], 13);
    check("t2_fall1", fall_t[0][1], 15);
    check("t2_rise2", rise_t[0][2], 17);
    check("t2_rise3", rise_t[0][3], 21);
    check("t2_tick_align", tick_bad, 0);

    // Test 3: ch0 H=3, disable one cycle into the high phase.
    do_reset();
    load = 3'b001;
    half_period = {16'd0, 16'd0, 16'd3};
    step();
    load = '0;
    enable = 3'b001;
    clear_watch();
    snap_a = '0;
    snap_b = '1;
    for (int c = 1; c <= 14; c++) begin
      step();
      watch(c);
      if (c == 5) enable = '0;
      if (c == 8) snap_a = busy;
      if (c == 9) snap_b = busy;
    end
    check("t3_rise",         rise_t[0][0], 5);
    check("t3_high_cycles",  nhi[0], 4);
    check("t3_fall",         fall_t[0][0], 9);
    check("t3_rise_count",   nr[0], 1);
    check("t3_busy_in_high", snap_a, 3'b001);
    check("t3_busy_after",   snap_b, 3'b000);
    // Disable during the low phase.
    enable = 3'b001;
    step();
    step();
    check("t3_low_busy", busy, 3'b001);
    check("t3_low_clock", clock_out, 3'b000);
    enable = '0;
    step();
    check("t3_low_disable_busy", busy, 3'b000);

    // Test 4: ch1 H=1, ch2 H=7 free-running, then sync.
    do_reset();
    load = 3'b110;
    half_period = {16'd7, 16'd1, 16'd0};
    step();
    load = '0;
    enable = 3'b110;
    for (int c = 0; c < 13; c++) step();
    sync = 1'b1;
    step();
    sync = 1'b0;
    check("t4_sync_low", clock_out, 3'b000);
    check("t4_sync_busy", busy, 3'b110);
    clear_watch();
    for (int c = 2; c <= 20; c++) begin
      step();
      watch(c);
      if (c == 16) snap_a = clock_out;
      if (c == 17) snap_b = clock_out;
    end
    check("t4_ch1_rise0", rise_t[1][0], 3);
    check("t4_ch1_rise1", rise_t[1][1], 7);
    check("t4_ch2_rise0", rise_t[2][0], 9);
    check("t4_c16", snap_a, 3'b110);
    check("t4_c17", snap_b, 3'b000);
    check("t4_tick_align", tick_bad, 0);
    check("t4_c20", clock_out, 3'b010);

    // Test 5: asynchronous reset while ch1 is high, enable left high.
    reset_n = 1'b0;
    #1;
    check("t5_async_clock", clock_out, 3'b000);
    check("t5_async_tick",  tick,      3'b000);
    check("t5_async_busy",  busy,      3'b000);
    #1 reset_n = 1'b1;
    step();
    check("t5_rel_c1_clock", clock_out, 3'b000);
    check("t5_rel_c1_busy",  busy,      3'b110);
    step();
    check("t5_rel_c2_clock", clock_out, 3'b110);
    check("t5_rel_c2_tick",  tick,      3'b110);

    // Test 6: load H=2 together with sync while ch0 runs at divide-by-2.
    do_reset();
    enable = 3'b001;
    for (int c = 0; c < 5; c++) step();
    load = 3'b001;
    half_period = {16'd0, 16'd0, 16'd2};
    sync = 1'b1;
    step();
    load = '0;
    sync = 1'b0;
    check("t6_sync_low", clock_out, 3'b000);
    clear_watch();
    for (int c = 2; c <= 12; c++) begin
      step();
      watch(c);
    end
    check("t6_rise0", rise_t[0][0], 4);
    check("t6_fall0", fall_t[0][0], 7);
    check("t6_rise1", rise_t[0][1], 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
